// File: rtl/spi_fl_xfer_pkg.sv
// Shared types for the flash SPI transfer queue: descriptor bit layout and FSM states.
package spi_fl_xfer_pkg;

  localparam int unsigned DESC_W    = 102;
  localparam int unsigned CMD_LSB   = 0;
  localparam int unsigned CTYPE_LSB = 8;
  localparam int unsigned ADDR_LSB  = 11;
  localparam int unsigned DIN_LSB   = 43;
  localparam int unsigned NBITS_LSB = 75;
  localparam int unsigned DUMMY_LSB = 82;
  localparam int unsigned FRAME_LSB = 86;
  localparam int unsigned XIP_LSB   = 96;
  localparam int unsigned MODE_LSB  = 98;
  localparam int unsigned DTR_BIT   = 100;
  localparam int unsigned FOURB_BIT = 101;

  // Same layout as the offsets above, MSB first.
  typedef struct packed {
    logic        fourbyteaddr_on;
    logic        dtr_en;
    logic [1:0]  spimode;
    logic [1:0]  xipbit_en;
    logic [9:0]  frame_struct;
    logic [3:0]  dummy_cycles;
    logic [6:0]  ndata_bits;
    logic [31:0] data_in;
    logic [31:0] address;
    logic [2:0]  commtype;
    logic [7:0]  command;
  } xfer_desc_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    HOLD      = 3'd2,
    WAIT_DONE = 3'd3,
    DRAIN     = 3'd4
  } xfer_state_e;

endpackage

// File: rtl/spi_fl_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head data reads as zero while empty.
module spi_fl_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/spi_fl_xfer_queue.sv
// Request/response queue in front of the flash SPI master.
// Optional WAIT_DONE watchdog with error responses: define SPI_FL_XFER_TIMEOUT_EN.
module spi_fl_xfer_queue
  import spi_fl_xfer_pkg::*;
#(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DESC_W-1:0] req_desc,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic              validflag,
  input  logic              tready,
  input  logic [31:0]       data_out,
  output logic [7:0]        command,
  output logic [2:0]        commtype,
  output logic [31:0]       address,
  output logic [31:0]       data_in,
  output logic [6:0]        ndata_bits,
  output logic [3:0]        dummy_cycles,
  output logic [9:0]        frame_struct,
  output logic [1:0]        xipbit_en,
  output logic [1:0]        spimode,
  output logic              dtr_en,
  output logic              fourbyteaddr_on
);

  xfer_state_e       state, state_n;
  logic              req_full, req_empty, req_pop;
  logic              rsp_full, rsp_empty, rsp_push, rsp_pop;
  logic [DESC_W-1:0] req_head, hold;
  logic [32:0]       rsp_wdata, rsp_head;

  assign req_ready = !req_full;
  assign rsp_valid = !rsp_empty;
  assign rsp_pop   = rsp_valid && rsp_ready;
  assign busy      = (state != IDLE) || !req_empty;
  assign rsp_data  = rsp_head[31:0];

  spi_fl_sync_fifo #(.WIDTH(DESC_W), .DEPTH(DEPTH)) u_req_fifo (
    .clk(clk), .rst(rst), .push(req_valid && req_ready), .wdata(req_desc),
    .pop(req_pop), .rdata(req_head), .full(req_full), .empty(req_empty)
  );

  spi_fl_sync_fifo #(.WIDTH(33), .DEPTH(DEPTH)) u_rsp_fifo (
    .clk(clk), .rst(rst), .push(rsp_push), .wdata(rsp_wdata),
    .pop(rsp_pop), .rdata(rsp_head), .full(rsp_full), .empty(rsp_empty)
  );

`ifdef SPI_FL_XFER_TIMEOUT_EN
  logic [15:0] timer;
  logic        timed_out;

  always_ff @(posedge clk) begin
    if (rst || state != WAIT_DONE) timer <= '0;
    else                           timer <= timer + 16'd1;
  end

  assign timed_out = (timer == 16'(TIMEOUT_CYCLES - 1));
  assign rsp_err   = rsp_head[32];
`else
  logic unused_bits;
  assign unused_bits = rsp_head[32] ^ (^TIMEOUT_CYCLES);
  assign rsp_err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Issuing only with a free response slot reserves that slot for the in-flight transfer.
  always_comb begin
    state_n   = state;
    req_pop   = 1'b0;
    rsp_push  = 1'b0;
    rsp_wdata = {1'b0, data_out};
    validflag = 1'b0;
    case (state)
      IDLE: begin
        if (!req_empty && !rsp_full) begin
          req_pop = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        validflag = 1'b1;
        if (tready) state_n = HOLD;
      end
      HOLD: state_n = WAIT_DONE;
      WAIT_DONE: begin
        if (tready) begin
          rsp_push = 1'b1;
          state_n  = IDLE;
        end
`ifdef SPI_FL_XFER_TIMEOUT_EN
        else if (timed_out) begin
          rsp_push  = 1'b1;
          rsp_wdata = {1'b1, 32'h0};
          state_n   = DRAIN;
        end
`endif
      end
`ifdef SPI_FL_XFER_TIMEOUT_EN
      DRAIN: begin
        if (tready) state_n = IDLE;
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)          hold <= '0;
    else if (req_pop) hold <= req_head;
  end

  assign command         = hold[CMD_LSB +: 8];
  assign commtype        = hold[CTYPE_LSB +: 3];
  assign address         = hold[ADDR_LSB +: 32];
  assign data_in         = hold[DIN_LSB +: 32];
  assign ndata_bits      = hold[NBITS_LSB +: 7];
  assign dummy_cycles    = hold[DUMMY_LSB +: 4];
  assign frame_struct    = hold[FRAME_LSB +: 10];
  assign xipbit_en       = hold[XIP_LSB +: 2];
  assign spimode         = hold[MODE_LSB +: 2];
  assign dtr_en          = hold[DTR_BIT];
  assign fourbyteaddr_on = hold[FOURB_BIT];

endmodule

// File: tb/tb_spi_fl_xfer_queue.sv
// Self-checking bench for spi_fl_xfer_queue with a behavioural SPI master model.
module tb_spi_fl_xfer_queue;
  import spi_fl_xfer_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 50;

  logic              clk = 1'b0;
  logic              rst, req_valid, rsp_ready, tready;
  logic              req_ready, rsp_valid, rsp_err, busy, validflag;
  logic [DESC_W-1:0] req_desc;
  logic [31:0]       rsp_data, data_out, address, data_in;
  logic [7:0]        command;
  logic [2:0]        commtype;
  logic [6:0]        ndata_bits;
  logic [3:0]        dummy_cycles;
  logic [9:0]        frame_struct;
  logic [1:0]        xipbit_en, spimode;
  logic              dtr_en, fourbyteaddr_on;

  int errors = 0;
  int checks = 0;

  spi_fl_xfer_queue #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_desc(req_desc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .validflag(validflag), .tready(tready), .data_out(data_out),
    .command(command), .commtype(commtype), .address(address), .data_in(data_in),
    .ndata_bits(ndata_bits), .dummy_cycles(dummy_cycles), .frame_struct(frame_struct),
    .xipbit_en(xipbit_en), .spimode(spimode), .dtr_en(dtr_en), .fourbyteaddr_on(fourbyteaddr_on)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Master model: knobs and logs
  int          m_lat = 2;
  int          m_stall = 0;
  bit          m_lat_rand = 1'b0;
  int          cyc = 0;
  logic [31:0] m_data_q[$];
  logic [31:0] ret_q[$];
  xfer_desc_t  hs_q[$];
  int          hs_cyc[$];

  function automatic xfer_desc_t cur_fields();
    return {fourbyteaddr_on, dtr_en, spimode, xipbit_en, frame_struct, dummy_cycles,
            ndata_bits, data_in, address, commtype, command};
  endfunction

  function automatic xfer_desc_t rand_desc();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return r[DESC_W-1:0];
  endfunction

  // Decides tready just after each rising edge for the following edge.
  initial begin : master
    int phase, left;
    bit pend;
    xfer_desc_t pd;
    logic [31:0] dv;
    tready = 1'b1; data_out = '0; phase = 0; left = 0; pend = 1'b0; pd = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rst) begin
        phase = 0; tready = 1'b1; pend = 1'b0;
      end else begin
        if (pend) begin
          hs_q.push_back(pd); hs_cyc.push_back(cyc); pend = 1'b0;
          phase = 1; left = m_lat_rand ? int'($urandom_range(1, 8)) : m_lat;
        end
        if (phase == 1) begin
          if (left > 0) begin
            tready = 1'b0; left--;
          end else begin
            dv = (m_data_q.size() > 0) ? m_data_q.pop_front() : $urandom();
            data_out = dv; ret_q.push_back(dv); tready = 1'b1; phase = 0;
          end
        end else if (validflag) begin
          if (m_stall > 0) begin
            tready = 1'b0; m_stall--;
          end else begin
            tready = 1'b1; pend = 1'b1; pd = cur_fields();
          end
        end else begin
          tready = 1'b1;
        end
      end
    end
  end

  task automatic push_desc(input xfer_desc_t d, output bit ok);
    ok = 1'b0; req_valid = 1'b1; req_desc = d;
    for (int i = 0; i < 2000; i++) begin
      if (req_ready) begin ok = 1'b1; @(negedge clk); break; end
      @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  task automatic pop_rsp(output logic [31:0] d, output logic e, output bit ok);
    ok = 1'b0; d = 'x; e = 'x; rsp_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (rsp_valid) begin d = rsp_data; e = rsp_err; ok = 1'b1; @(negedge clk); break; end
      @(negedge clk);
    end
    rsp_ready = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (!busy) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_desc = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (validflag !== 1'b0) begin errors++; $display("FAIL reset_validflag: got %b expected 0", validflag); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (rsp_data !== 32'h0 || rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp: got %h/%b expected 0/0", rsp_data, rsp_err); end
    checks++; if (cur_fields() !== xfer_desc_t'('0)) begin errors++; $display("FAIL reset_fields: got %h expected 0", cur_fields()); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    xfer_desc_t d; bit ok; logic [31:0] rd; logic re;
    hs_q.delete(); ret_q.delete();
    d = '0; d.command = 8'h03; d.address = 32'h0000_0100; d.ndata_bits = 7'd32;
    m_lat = 21; m_data_q.push_back(32'hDEADBEEF);
    push_desc(d, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_push: got not accepted expected accepted"); end
    @(negedge clk);
    wait_idle(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_done: got busy expected idle within bound"); end
    checks++; if (hs_q.size() != 1) begin errors++; $display("FAIL single_handshakes: got %0d expected 1", hs_q.size()); end
    checks++; if ((hs_q.size() > 0 ? hs_q[0] : ~d) !== d) begin errors++; $display("FAIL single_fields: got %h expected %h", (hs_q.size() > 0 ? hs_q[0] : ~d), d); end
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rsp: got %b/%h expected 1/deadbeef", rsp_valid, rsp_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b expected 0", busy); end
    pop_rsp(rd, re, ok);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_popped: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_back_to_back();
    xfer_desc_t exp[$]; xfer_desc_t d; bit ok; logic [31:0] rd, ed; logic re;
    hs_q.delete(); hs_cyc.delete(); ret_q.delete();
    m_lat = 6; rsp_ready = 1'b0;
    for (int i = 1; i <= DEPTH + 1; i++) begin
      d = rand_desc(); d.command = 8'(i); exp.push_back(d);
      push_desc(d, ok);
      checks++; if (!ok) begin errors++; $display("FAIL b2b_push%0d: got not accepted expected accepted", i); end
    end
    // One descriptor is in flight, DEPTH are queued.
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_full: got req_ready=%b expected 0", req_ready); end
    for (int i = 0; i <= DEPTH; i++) begin
      pop_rsp(rd, re, ok);
      ed = (ret_q.size() > 0) ? ret_q.pop_front() : ~rd;
      checks++; if (!ok || rd !== ed || re !== 1'b0) begin errors++; $display("FAIL b2b_rsp%0d: got %h/%b expected %h/0", i, rd, re, ed); end
    end
    checks++; if (hs_q.size() != DEPTH + 1) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", hs_q.size(), DEPTH + 1); end
    for (int i = 0; i < hs_q.size() && i <= DEPTH; i++) begin
      checks++; if (hs_q[i] !== exp[i]) begin errors++; $display("FAIL b2b_order%0d: got cmd %h expected cmd %h", i, hs_q[i].command, exp[i].command); end
      if (i > 0) begin
        checks++; if (hs_cyc[i] - hs_cyc[i-1] < m_lat + 3) begin errors++; $display("FAIL b2b_gap%0d: got %0d cycles expected >= %0d", i, hs_cyc[i] - hs_cyc[i-1], m_lat + 3); end
      end
    end
  endtask

  task automatic test_rsp_backpressure();
    xfer_desc_t exp[$]; xfer_desc_t d; bit ok; logic [31:0] rd, ed; logic re;
    hs_q.delete(); ret_q.delete();
    m_lat = 2; rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      d = rand_desc(); exp.push_back(d); push_desc(d, ok);
      checks++; if (!ok) begin errors++; $display("FAIL bp_push%0d: got not accepted expected accepted", i); end
    end
    repeat (80) @(negedge clk);
    checks++; if (hs_q.size() != DEPTH) begin errors++; $display("FAIL bp_issued: got %0d expected %0d", hs_q.size(), DEPTH); end
    checks++; if (validflag !== 1'b0 || busy !== 1'b1 || rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_stalled: got vf=%b busy=%b rv=%b expected 0/1/1", validflag, busy, rsp_valid); end
    pop_rsp(rd, re, ok);
    ed = (ret_q.size() > 0) ? ret_q.pop_front() : ~rd;
    checks++; if (!ok || rd !== ed) begin errors++; $display("FAIL bp_rsp0: got %h expected %h", rd, ed); end
    @(negedge clk);
    checks++; if (validflag !== 1'b1) begin errors++; $display("FAIL bp_reissue: got validflag=%b expected 1", validflag); end
    for (int i = 1; i < 6; i++) begin
      pop_rsp(rd, re, ok);
      ed = (ret_q.size() > 0) ? ret_q.pop_front() : ~rd;
      checks++; if (!ok || rd !== ed || re !== 1'b0) begin errors++; $display("FAIL bp_rsp%0d: got %h/%b expected %h/0", i, rd, re, ed); end
    end
    checks++; if (hs_q.size() != 6) begin errors++; $display("FAIL bp_total: got %0d expected 6", hs_q.size()); end
    for (int i = 0; i < hs_q.size() && i < 6; i++) begin
      checks++; if (hs_q[i] !== exp[i]) begin errors++; $display("FAIL bp_order%0d: got %h expected %h", i, hs_q[i], exp[i]); end
    end
  endtask

  task automatic test_slow_accept();
    xfer_desc_t d; bit ok; int n; logic [31:0] rd, ed; logic re;
    hs_q.delete(); ret_q.delete();
    m_lat = 3; m_stall = 10; d = rand_desc();
    push_desc(d, ok);
    n = 0;
    while (!validflag && n < 20) begin @(negedge clk); n++; end
    checks++; if (validflag !== 1'b1) begin errors++; $display("FAIL slow_issue: got validflag=%b expected 1", validflag); end
    for (int i = 0; i < 10; i++) begin
      checks++; if (validflag !== 1'b1 || cur_fields() !== d || hs_q.size() != 0) begin errors++; $display("FAIL slow_hold%0d: got vf=%b hs=%0d fields=%h expected 1/0/%h", i, validflag, hs_q.size(), cur_fields(), d); end
      @(negedge clk);
    end
    checks++; if (validflag !== 1'b1 || hs_q.size() != 0) begin errors++; $display("FAIL slow_last: got vf=%b hs=%0d expected 1/0", validflag, hs_q.size()); end
    @(negedge clk);
    checks++; if (validflag !== 1'b0 || hs_q.size() != 1) begin errors++; $display("FAIL slow_handshake: got vf=%b hs=%0d expected 0/1", validflag, hs_q.size()); end
    checks++; if (cur_fields() !== d) begin errors++; $display("FAIL slow_fields_after: got %h expected %h", cur_fields(), d); end
    wait_idle(100, ok);
    pop_rsp(rd, re, ok);
    ed = (ret_q.size() > 0) ? ret_q.pop_front() : ~rd;
    checks++; if (!ok || rd !== ed) begin errors++; $display("FAIL slow_rsp: got %h expected %h", rd, ed); end
  endtask

  task automatic test_reset_mid();
    bit ok; int n;
    hs_q.delete(); ret_q.delete();
    m_lat = 30;
    for (int i = 0; i < 3; i++) push_desc(rand_desc(), ok);
    n = 0;
    while (hs_q.size() == 0 && n < 50) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (validflag !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out: got vf=%b rv=%b expected 0/0", validflag, rsp_valid); end
    checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_state: got rr=%b busy=%b expected 1/0", req_ready, busy); end
    rst = 1'b0;
    repeat (60) @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || hs_q.size() != 1 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_quiet: got rv=%b hs=%0d busy=%b expected 0/1/0", rsp_valid, hs_q.size(), busy); end
  endtask

  task automatic test_random();
    xfer_desc_t exp[$];
    localparam int N = 24;
    hs_q.delete(); ret_q.delete();
    m_lat_rand = 1'b1;
    fork
      begin
        xfer_desc_t d; bit ok;
        for (int i = 0; i < N; i++) begin
          d = rand_desc(); push_desc(d, ok); exp.push_back(d);
          checks++; if (!ok) begin errors++; $display("FAIL rnd_push%0d: got not accepted expected accepted", i); end
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
      end
      begin
        logic [31:0] rd, ed; logic re; bit ok;
        for (int i = 0; i < N; i++) begin
          repeat ($urandom_range(0, 4)) @(negedge clk);
          pop_rsp(rd, re, ok);
          ed = (ret_q.size() > 0) ? ret_q.pop_front() : ~rd;
          checks++; if (!ok || rd !== ed || re !== 1'b0) begin errors++; $display("FAIL rnd_rsp%0d: got %h/%b expected %h/0", i, rd, re, ed); end
        end
      end
    join
    m_lat_rand = 1'b0;
    checks++; if (hs_q.size() != N) begin errors++; $display("FAIL rnd_count: got %0d expected %0d", hs_q.size(), N); end
    for (int i = 0; i < hs_q.size() && i < N; i++) begin
      checks++; if (hs_q[i] !== exp[i]) begin errors++; $display("FAIL rnd_order%0d: got %h expected %h", i, hs_q[i], exp[i]); end
    end
  endtask

`ifdef SPI_FL_XFER_TIMEOUT_EN
  task automatic test_timeout();
    xfer_desc_t d1, d2; bit ok, early; int n; logic [31:0] rd, ed; logic re;
    hs_q.delete(); ret_q.delete();
    m_lat = 200; d1 = rand_desc(); d2 = rand_desc();
    push_desc(d1, ok); push_desc(d2, ok);
    n = 0;
    while (hs_q.size() == 0 && n < 50) begin @(negedge clk); n++; end
    n = 0;
    while (!rsp_valid && n < 400) begin @(negedge clk); n++; end
    checks++; if (n < int'(TMO) || n > int'(TMO) + 2) begin errors++; $display("FAIL tmo_latency: got %0d cycles expected %0d..%0d", n, TMO, TMO + 2); end
    checks++; if (rsp_err !== 1'b1 || rsp_data !== 32'h0) begin errors++; $display("FAIL tmo_rsp: got %b/%h expected 1/0", rsp_err, rsp_data); end
    pop_rsp(rd, re, ok);
    early = 1'b0; n = 0;
    while (ret_q.size() == 0 && n < 300) begin
      if (validflag || hs_q.size() != 1) early = 1'b1;
      @(negedge clk); n++;
    end
    checks++; if (early || ret_q.size() != 1) begin errors++; $display("FAIL tmo_drain: got early=%b ret=%0d expected 0/1", early, ret_q.size()); end
    void'(ret_q.pop_front());
    m_lat = 3; n = 0;
    while (hs_q.size() < 2 && n < 50) begin @(negedge clk); n++; end
    checks++; if ((hs_q.size() > 1 ? hs_q[1] : ~d2) !== d2) begin errors++; $display("FAIL tmo_next: got %0d handshakes expected d2 issued", hs_q.size()); end
    pop_rsp(rd, re, ok);
    ed = (ret_q.size() > 0) ? ret_q.pop_front() : ~rd;
    checks++; if (!ok || rd !== ed || re !== 1'b0) begin errors++; $display("FAIL tmo_rsp2: got %h/%b expected %h/0", rd, re, ed); end
  endtask
`endif

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_desc = '0; rsp_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_read();
    test_back_to_back();
    test_rsp_backpressure();
    test_slow_accept();
    test_reset_mid();
    test_random();
`ifdef SPI_FL_XFER_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
